// File: rtl/hmain0_ahb_pkg.sv
// rtl/hmain0_ahb_pkg.sv - shared AHB encodings, slave state enum and lane-mask helper
package hmain0_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  // Little-endian byte lanes touched by an aligned transfer of the given size.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << lo;
      HSIZE_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/hmain0_ahb_slv_mem.sv
// rtl/hmain0_ahb_slv_mem.sv - DEPTH x 32 storage, byte-enabled synchronous write, asynchronous read
module hmain0_ahb_slv_mem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/hmain0_ahb_slv_resp.sv
// rtl/hmain0_ahb_slv_resp.sv - AHB-Lite memory slave with OKAY and two-cycle ERROR responses
// Optional OKAY wait states enabled by defining HMAIN0_AHB_SLV_WAIT_STATE_EN.
module hmain0_ahb_slv_resp
  import hmain0_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        pad_core_clk,
  input  logic        pad_core_rst_b,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic [31:0] hrdata,
  output logic        hready_out,
  output logic [1:0]  hresp
);

  localparam int unsigned AW       = $clog2(MEM_DEPTH);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * MEM_DEPTH);

  state_e      state_q, state_d, okay_next;
  logic        dp_act_q;
  logic [31:0] addr_q;
  logic        write_q;
  logic [2:0]  size_q;

  logic        is_xfer, accept, addr_err, size_err, align_err, xfer_err;
  logic        wait_done;
  logic [31:0] offset;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic        unused_bits;

  assign is_xfer   = !(htrans == HTRANS_IDLE || htrans == HTRANS_BUSY);
  assign accept    = hsel & hready_in & is_xfer;
  assign addr_err  = ({1'b0, haddr} < {1'b0, BASE_ADDR}) || ({1'b0, haddr} >= END_ADDR);
  assign size_err  = hsize > HSIZE_WORD;
  assign align_err = ((hsize == HSIZE_HALF) && haddr[0]) ||
                     ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
  assign xfer_err  = addr_err | size_err | align_err;

`ifdef HMAIN0_AHB_SLV_WAIT_STATE_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  logic [3:0] wait_cnt_q;

  assign okay_next = (WAIT_LOAD != 4'd0) ? ST_WAIT : ST_IDLE;
  assign wait_done = (wait_cnt_q <= 4'd1);

  always_ff @(posedge pad_core_clk or negedge pad_core_rst_b) begin
    if (!pad_core_rst_b) begin
      wait_cnt_q <= 4'd0;
    end else if (state_d == ST_WAIT && state_q != ST_WAIT) begin
      wait_cnt_q <= WAIT_LOAD;
    end else if (state_q == ST_WAIT) begin
      wait_cnt_q <= wait_cnt_q - 4'd1;
    end
  end
`else
  logic [3:0] unused_wait;
  assign unused_wait = 4'(WAIT_CYCLES);
  assign okay_next   = ST_IDLE;
  assign wait_done   = 1'b1;
`endif

  // State and address-phase capture; fields only move when the current data phase completes.
  always_ff @(posedge pad_core_clk or negedge pad_core_rst_b) begin
    if (!pad_core_rst_b) begin
      state_q  <= ST_IDLE;
      dp_act_q <= 1'b0;
      addr_q   <= 32'd0;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      if (hready_out) begin
        dp_act_q <= accept & ~xfer_err;
        if (accept) begin
          addr_q  <= haddr;
          write_q <= hwrite;
          size_q  <= hsize;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT: if (wait_done) state_d = ST_IDLE;
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = accept ? (xfer_err ? ST_ERR1 : okay_next) : ST_IDLE;
    endcase
  end

  always_comb begin
    hready_out = 1'b1;
    hresp      = HRESP_OKAY;
    hrdata     = 32'd0;
    unique case (state_q)
      ST_WAIT: hready_out = 1'b0;
      ST_ERR1: begin
        hready_out = 1'b0;
        hresp      = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: if (dp_act_q && !write_q) hrdata = mem_rdata;
    endcase
  end

  assign offset = addr_q - BASE_ADDR;
  assign mem_we = (state_q == ST_IDLE) && dp_act_q && write_q;

  hmain0_ahb_slv_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (pad_core_clk),
    .we    (mem_we),
    .be    (lane_mask(size_q, addr_q[1:0])),
    .addr  (offset[AW+1:2]),
    .wdata (hwdata),
    .rdata (mem_rdata)
  );

  assign unused_bits = ^{offset[31:AW+2], offset[1:0], hburst, hprot};

endmodule
